// File: rtl/duty_reporter.sv
// duty_reporter: formats the current duty cycle as "D=nnn\r\n" and streams it byte by byte to a
// UART transmitter over a start/busy handshake, on request or whenever the duty cycle changes.
module duty_reporter #(
  parameter logic [7:0] PREFIX      = 8'h44,
  parameter bit         AUTO_REPORT = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] duty_cycle,
  input  logic       report_req,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       busy
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StConvH    = 3'd1;
  localparam logic [2:0] StConvT    = 3'd2;
  localparam logic [2:0] StSend     = 3'd3;
  localparam logic [2:0] StWaitAck  = 3'd4;
  localparam logic [2:0] StWaitDone = 3'd5;

  localparam logic [2:0] LastIdx = 3'd6;

  logic [2:0] state_q, state_d;
  logic [7:0] val_q, val_d;
  logic [1:0] hund_q, hund_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic [2:0] idx_q, idx_d;
  logic       pending_q, pending_d;
  logic [7:0] last_q, last_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_start_q, tx_start_d;

  logic       changed;
  logic       start_conv;
  logic [7:0] frame_byte;

  // Auto-report only ever compares against the value that was last put on the wire.
  assign changed = AUTO_REPORT && (duty_cycle != last_q);

  always_comb begin
    case (idx_q)
      3'd0:    frame_byte = PREFIX;
      3'd1:    frame_byte = 8'h3D;
      3'd2:    frame_byte = 8'h30 + {6'd0, hund_q};
      3'd3:    frame_byte = 8'h30 + {4'd0, tens_q};
      3'd4:    frame_byte = 8'h30 + {4'd0, ones_q};
      3'd5:    frame_byte = 8'h0D;
      default: frame_byte = 8'h0A;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    val_d      = val_q;
    hund_d     = hund_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    idx_d      = idx_q;
    pending_d  = pending_q;
    last_d     = last_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    start_conv = 1'b0;

    // Requests during a frame collapse into a single follow-up report.
    if (state_q != StIdle && report_req) begin
      pending_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (report_req || changed) begin
          start_conv = 1'b1;
        end
      end
      StConvH: begin
        if (val_q >= 8'd100) begin
          val_d  = val_q - 8'd100;
          hund_d = hund_q + 2'd1;
        end else begin
          state_d = StConvT;
        end
      end
      StConvT: begin
        if (val_q >= 8'd10) begin
          val_d  = val_q - 8'd10;
          tens_d = tens_q + 4'd1;
        end else begin
          ones_d  = val_q[3:0];
          state_d = StSend;
        end
      end
      StSend: begin
        if (!tx_busy) begin
          tx_data_d  = frame_byte;
          tx_start_d = 1'b1;
          state_d    = StWaitAck;
        end
      end
      StWaitAck: begin
        if (tx_busy) begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (!tx_busy) begin
          if (idx_q == LastIdx) begin
            if (pending_q || report_req) begin
              start_conv = 1'b1;
            end else begin
              idx_d   = 3'd0;
              state_d = StIdle;
            end
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = StSend;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Fresh snapshot of the duty cycle for a new frame, whether from idle or back-to-back.
    if (start_conv) begin
      val_d     = duty_cycle;
      last_d    = duty_cycle;
      hund_d    = 2'd0;
      tens_d    = 4'd0;
      ones_d    = 4'd0;
      idx_d     = 3'd0;
      pending_d = 1'b0;
      state_d   = StConvH;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      val_q      <= 8'd0;
      hund_q     <= 2'd0;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
      idx_q      <= 3'd0;
      pending_q  <= 1'b0;
      last_q     <= 8'd0;
      tx_data_q  <= 8'd0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      val_q      <= val_d;
      hund_q     <= hund_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      last_q     <= last_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_duty_reporter.sv
// Bench for duty_reporter: a request-only and an auto-report instance, each driving its own
// behavioural UART model, checked against frames computed from the decimal value directly.
module tb_duty_reporter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] duty [2];
  logic       req [2];
  logic       hold [2];
  logic       txb_r [2] = '{1'b0, 1'b0};
  int         cnt [2] = '{0, 0};
  logic       tx_busy_w [2];
  logic [7:0] tx_data [2];
  logic       tx_start [2];
  logic       busy [2];

  logic [7:0] cap [2][512];
  int         ncap [2] = '{0, 0};
  int         viol [2] = '{0, 0};
  int         tx_len = 10;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  assign tx_busy_w[0] = txb_r[0] | hold[0];
  assign tx_busy_w[1] = txb_r[1] | hold[1];

  duty_reporter #(.PREFIX(8'h44), .AUTO_REPORT(1'b0)) dut_man (
    .clk        (clk),
    .reset_n    (reset_n),
    .duty_cycle (duty[0]),
    .report_req (req[0]),
    .tx_busy    (tx_busy_w[0]),
    .tx_data    (tx_data[0]),
    .tx_start   (tx_start[0]),
    .busy       (busy[0])
  );

  duty_reporter #(.PREFIX(8'h44), .AUTO_REPORT(1'b1)) dut_auto (
    .clk        (clk),
    .reset_n    (reset_n),
    .duty_cycle (duty[1]),
    .report_req (req[1]),
    .tx_busy    (tx_busy_w[1]),
    .tx_data    (tx_data[1]),
    .tx_start   (tx_start[1]),
    .busy       (busy[1])
  );

  // UART model: accepts a start while idle, then stays busy for tx_len cycles.
  always @(posedge clk or negedge reset_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        txb_r[i] <= 1'b0;
        cnt[i]   <= 0;
      end else if (tx_start[i]) begin
        if (tx_busy_w[i]) begin
          viol[i] <= viol[i] + 1;
        end else begin
          cap[i][ncap[i] % 512] <= tx_data[i];
          ncap[i]  <= ncap[i] + 1;
          txb_r[i] <= 1'b1;
          cnt[i]   <= tx_len;
        end
      end else if (txb_r[i]) begin
        if (cnt[i] <= 1) txb_r[i] <= 1'b0;
        else cnt[i] <= cnt[i] - 1;
      end
    end
  end

  function automatic logic [7:0] exp_byte(input int k, input int v);
    case (k)
      0:       return 8'h44;
      1:       return 8'h3D;
      2:       return 8'(48 + v / 100);
      3:       return 8'(48 + (v / 10) % 10);
      4:       return 8'(48 + v % 10);
      5:       return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req(input int i);
    req[i] = 1'b1;
    tick();
    req[i] = 1'b0;
  endtask

  task automatic run_until_idle(input int i, input int budget, output int starts, output bit ok);
    starts = 0;
    ok     = 1'b0;
    for (int n = 0; n < budget; n++) begin
      tick();
      if (tx_start[i]) starts++;
      if (!busy[i]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_bytes(input int i, input int target, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 500; n++) begin
      if (ncap[i] >= target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      duty[i] = 8'd0;
      req[i]  = 1'b0;
      hold[i] = 1'b0;
    end
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (tx_data[i] !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_tx_data[%0d]: got %h want 00", i, tx_data[i]);
      end
      n_checks++;
      if (tx_start[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_tx_start[%0d]: got %b want 0", i, tx_start[i]);
      end
      n_checks++;
      if (busy[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_busy[%0d]: got %b want 0", i, busy[i]);
      end
    end
    reset_n = 1'b1;
    repeat (10) tick();
    n_checks++;
    if (busy[1] !== 1'b0 || ncap[1] !== 0) begin
      n_fail++;
      $display("FAIL reset_no_auto: busy %b bytes %0d want 0 0", busy[1], ncap[1]);
    end
  endtask

  task automatic test_frame50();
    int base, v0, starts;
    bit ok;
    logic [7:0] got;
    tx_len  = 10;
    duty[0] = 8'd50;
    base    = ncap[0];
    v0      = viol[0];
    pulse_req(0);
    run_until_idle(0, 1000, starts, ok);
    n_checks++;
    if (!ok || starts != 7 || ncap[0] - base != 7) begin
      n_fail++;
      $display("FAIL frame50_count: done %b starts %0d bytes %0d want 1 7 7",
               ok, starts, ncap[0] - base);
    end
    for (int k = 0; k < 7; k++) begin
      got = cap[0][(base + k) % 512];
      n_checks++;
      if (got !== exp_byte(k, 50)) begin
        n_fail++;
        $display("FAIL frame50_byte%0d: got %h want %h", k, got, exp_byte(k, 50));
      end
    end
    n_checks++;
    if (viol[0] != v0) begin
      n_fail++;
      $display("FAIL frame50_start_while_busy: got %0d want 0", viol[0] - v0);
    end
  endtask

  task automatic test_latency();
    int vals [2] = '{255, 0};
    int lats [2] = '{10, 3};
    int base, lat, starts;
    bit ok, found;
    logic [7:0] got;
    tx_len = 4;
    for (int t = 0; t < 2; t++) begin
      duty[0] = 8'(vals[t]);
      base    = ncap[0];
      pulse_req(0);
      lat   = 0;
      found = 1'b0;
      for (int n = 0; n < 40; n++) begin
        tick();
        lat++;
        if (tx_start[0]) begin
          found = 1'b1;
          break;
        end
      end
      n_checks++;
      if (!found || lat != lats[t]) begin
        n_fail++;
        $display("FAIL latency_%0d: got %0d (seen %b) want %0d", vals[t], lat, found, lats[t]);
      end
      run_until_idle(0, 500, starts, ok);
      n_checks++;
      if (!ok || starts + 1 != 7) begin
        n_fail++;
        $display("FAIL latency_%0d_starts: done %b starts %0d want 1 7", vals[t], ok, starts + 1);
      end
      for (int k = 0; k < 7; k++) begin
        got = cap[0][(base + k) % 512];
        n_checks++;
        if (got !== exp_byte(k, vals[t])) begin
          n_fail++;
          $display("FAIL latency_%0d_byte%0d: got %h want %h", vals[t], k, got,
                   exp_byte(k, vals[t]));
        end
      end
    end
  endtask

  task automatic test_auto();
    int base, starts;
    bit ok;
    logic [7:0] got;
    tx_len  = 5;
    base    = ncap[1];
    duty[1] = 8'd90;
    tick();
    n_checks++;
    if (busy[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL auto_trigger: busy got %b want 1", busy[1]);
    end
    run_until_idle(1, 500, starts, ok);
    n_checks++;
    if (!ok || starts != 7) begin
      n_fail++;
      $display("FAIL auto_starts: done %b starts %0d want 1 7", ok, starts);
    end
    for (int k = 0; k < 7; k++) begin
      got = cap[1][(base + k) % 512];
      n_checks++;
      if (got !== exp_byte(k, 90)) begin
        n_fail++;
        $display("FAIL auto_byte%0d: got %h want %h", k, got, exp_byte(k, 90));
      end
    end
    repeat (50) tick();
    n_checks++;
    if (ncap[1] - base != 7 || busy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL auto_no_repeat: bytes %0d busy %b want 7 0", ncap[1] - base, busy[1]);
    end
  endtask

  task automatic test_back_to_back();
    int base, starts;
    bit ok;
    logic [7:0] got;
    tx_len  = 8;
    duty[0] = 8'd50;
    base    = ncap[0];
    pulse_req(0);
    wait_bytes(0, base + 2, ok);
    duty[0] = 8'd20;
    pulse_req(0);
    if (ok) wait_bytes(0, base + 3, ok);
    pulse_req(0);
    if (ok) wait_bytes(0, base + 4, ok);
    pulse_req(0);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL b2b_progress: got stalled want bytes flowing");
    end
    run_until_idle(0, 2000, starts, ok);
    n_checks++;
    if (!ok || ncap[0] - base != 14) begin
      n_fail++;
      $display("FAIL b2b_busy_continuous: done %b bytes at busy fall %0d want 1 14",
               ok, ncap[0] - base);
    end
    for (int k = 0; k < 14; k++) begin
      got = cap[0][(base + k) % 512];
      n_checks++;
      if (got !== exp_byte(k % 7, (k < 7) ? 50 : 20)) begin
        n_fail++;
        $display("FAIL b2b_byte%0d: got %h want %h", k, got,
                 exp_byte(k % 7, (k < 7) ? 50 : 20));
      end
    end
    repeat (40) tick();
    n_checks++;
    if (ncap[0] - base != 14) begin
      n_fail++;
      $display("FAIL b2b_single_extra: got %0d bytes want 14", ncap[0] - base);
    end
  endtask

  task automatic test_busy_held();
    int base, v0, starts;
    bit ok;
    logic [7:0] got;
    tx_len  = 6;
    hold[0] = 1'b1;
    tick();
    duty[0] = 8'd123;
    base    = ncap[0];
    v0      = viol[0];
    pulse_req(0);
    starts = 0;
    repeat (40) begin
      tick();
      if (tx_start[0]) starts++;
    end
    n_checks++;
    if (starts != 0 || busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL held_no_start: starts %0d busy %b want 0 1", starts, busy[0]);
    end
    hold[0] = 1'b0;
    run_until_idle(0, 500, starts, ok);
    n_checks++;
    if (!ok || starts != 7 || viol[0] != v0) begin
      n_fail++;
      $display("FAIL held_frame: done %b starts %0d violations %0d want 1 7 0",
               ok, starts, viol[0] - v0);
    end
    for (int k = 0; k < 7; k++) begin
      got = cap[0][(base + k) % 512];
      n_checks++;
      if (got !== exp_byte(k, 123)) begin
        n_fail++;
        $display("FAIL held_byte%0d: got %h want %h", k, got, exp_byte(k, 123));
      end
    end
  endtask

  task automatic test_reset_mid();
    int base, starts;
    bit ok;
    logic [7:0] got;
    tx_len  = 10;
    duty[0] = 8'd77;
    base    = ncap[0];
    pulse_req(0);
    wait_bytes(0, base + 4, ok);
    tick();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (!ok || tx_data[0] !== 8'h00 || tx_start[0] !== 1'b0 || busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: reached %b data %h start %b busy %b want 1 00 0 0",
               ok, tx_data[0], tx_start[0], busy[0]);
    end
    tick();
    reset_n = 1'b1;
    tick();
    duty[0] = 8'd200;
    base    = ncap[0];
    pulse_req(0);
    run_until_idle(0, 500, starts, ok);
    n_checks++;
    if (!ok || starts != 7) begin
      n_fail++;
      $display("FAIL midreset_restart: done %b starts %0d want 1 7", ok, starts);
    end
    for (int k = 0; k < 7; k++) begin
      got = cap[0][(base + k) % 512];
      n_checks++;
      if (got !== exp_byte(k, 200)) begin
        n_fail++;
        $display("FAIL midreset_byte%0d: got %h want %h", k, got, exp_byte(k, 200));
      end
    end
  endtask

  task automatic test_random();
    int v, base, lat, want_lat, starts;
    bit ok, found;
    logic [7:0] got;
    for (int t = 0; t < 8; t++) begin
      v        = int'($urandom_range(0, 255));
      tx_len   = int'($urandom_range(1, 6));
      duty[0]  = 8'(v);
      want_lat = (v / 100 + 1) + ((v / 10) % 10 + 1) + 1;
      base     = ncap[0];
      pulse_req(0);
      lat   = 0;
      found = 1'b0;
      for (int n = 0; n < 40; n++) begin
        tick();
        lat++;
        if (tx_start[0]) begin
          found = 1'b1;
          break;
        end
      end
      n_checks++;
      if (!found || lat != want_lat) begin
        n_fail++;
        $display("FAIL rand_latency_%0d: got %0d (seen %b) want %0d", v, lat, found, want_lat);
      end
      run_until_idle(0, 500, starts, ok);
      n_checks++;
      if (!ok || starts + 1 != 7) begin
        n_fail++;
        $display("FAIL rand_starts_%0d: done %b starts %0d want 1 7", v, ok, starts + 1);
      end
      for (int k = 0; k < 7; k++) begin
        got = cap[0][(base + k) % 512];
        n_checks++;
        if (got !== exp_byte(k, v)) begin
          n_fail++;
          $display("FAIL rand_%0d_byte%0d: got %h want %h", v, k, got, exp_byte(k, v));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame50();
    test_latency();
    test_auto();
    test_back_to_back();
    test_busy_held();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/duty_reporter.md
# duty_reporter

Status transmitter for the UART/PWM LED design: formats the current 8-bit duty cycle as a 7-byte ASCII frame, `D=nnn\r\n`, and feeds it byte-by-byte to the UART transmitter through a start/busy handshake. It is the outbound counterpart of the command parser, which sets the duty cycle from received bytes; this block reports the duty cycle back to the host, on request and optionally whenever it changes.

## Interface
- `PREFIX`, default 8'h44 ("D"): first byte of every frame.
- `AUTO_REPORT`, default 1: 1 = a change of `duty_cycle` from the last reported value triggers a report; 0 = reports only on `report_req`.
- `clk` input 1: system clock; all logic on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `duty_cycle` input 8: current duty cycle, binary 0–255.
- `report_req` input 1: single-cycle request pulse; sampled each clock.
- `tx_busy` input 1: UART transmitter busy; goes high the cycle after an accepted `tx_start`, low when the byte is finished.
- `tx_data` output 8: byte presented to the transmitter; stable from `tx_start` until that byte completes.
- `tx_start` output 1: one-cycle pulse, only when `tx_busy` is low.
- `busy` output 1: high from the trigger cycle until the last byte completes.

## Operation
- Frame is fixed at 7 bytes: `PREFIX`, 8'h3D ("="), hundreds, tens, ones, 8'h0D, 8'h0A.
- Digits are always three wide, zero-padded, encoded as 8'h30 + digit. Example: 0 → "000", 255 → "255".
- Trigger sources:
  - `report_req` high.
  - With `AUTO_REPORT`=1, `duty_cycle` ≠ `last_reported`. `last_reported` resets to 0, so no report fires at reset.
- On a trigger in IDLE, snapshot `duty_cycle` into `val` and `last_reported`, then go to CONV_H.
- States:
  - IDLE: wait for a trigger.
  - CONV_H: if `val` ≥ 100, `val` −= 100 and hundreds++; else go to CONV_T. One subtraction per cycle.
  - CONV_T: if `val` ≥ 10, `val` −= 10 and tens++; else ones = `val[3:0]` and go to SEND.
  - SEND: when `tx_busy` is low, drive `tx_data` = frame[idx] and pulse `tx_start`; go to WAIT_ACK.
  - WAIT_ACK: wait for `tx_busy` high.
  - WAIT_DONE: wait for `tx_busy` low. If idx = 6, go to IDLE (or start the pending report); else idx++ and go to SEND.
- Digit counters are 2 bits (hundreds, max 2) and 4 bits (tens and ones, max 9). `val` is 8 bits and never underflows.
- Pending request: a trigger arriving while `busy` sets a 1-deep `pending` flag; further triggers are merged into it. When the frame ends, a set `pending` starts a new report using a fresh snapshot of `duty_cycle`, and `pending` clears.
- Auto-report compares against `last_reported` only in IDLE. A change during a frame is detected after the frame ends.
- `tx_busy` stuck high: the block waits indefinitely. No timeout.
- Reset values: `tx_data`=0, `tx_start`=0, `busy`=0, `pending`=0, `last_reported`=0, state IDLE, idx=0.
- Reset asserted mid-frame aborts immediately. The partial frame is not resumed.

## Timing
- Trigger sampled at edge 0. `busy` is high from the next cycle.
- Conversion takes (H+1)+(T+1) cycles, where H and T are the hundreds and tens digits: 2 cycles for value 0, 9 cycles for value 255.
- First `tx_start` occurs in the first SEND cycle in which `tx_busy` is low.
- Between bytes: `tx_start` is issued at the earliest in the cycle after `tx_busy` is observed falling.
- `busy` falls in the cycle after WAIT_DONE for byte 6 sees `tx_busy` low, unless a pending report starts. In that case `busy` stays high continuously.
- `tx_start` is never asserted while `tx_busy` is high, and never twice for one byte.

## Test plan
- `duty_cycle`=50, `report_req` pulse, transmitter model with 10-cycle busy → bytes 44 3D 30 35 30 0D 0A in order, exactly 7 `tx_start` pulses, then `busy` falls.
- `duty_cycle`=255, `AUTO_REPORT`=0 → digits 32 35 35; first `tx_start` exactly 10 cycles after the request with `tx_busy` idle. `duty_cycle`=0 → digits 30 30 30; first `tx_start` 3 cycles after the request.
- `AUTO_REPORT`=1, `duty_cycle` steps 0→90 → one frame "D=090\r\n", with no request and no repeat while the value stays 90.
- Three `report_req` pulses during a frame, with `duty_cycle` changed to 20 mid-frame → exactly one extra frame, reporting 020, and `busy` stays continuously high.
- `tx_busy` held high before the request → no `tx_start` until `tx_busy` drops; the frame is then correct.
- `reset_n` low during byte 3 → all outputs 0 at once; after release, a new request sends a complete 7-byte frame starting with 44.
